pulse_meter: RTL and testbench

Measures the length, in clock cycles, of each high pulse on a single-bit input. It then presents the count to a consumer through a valid/ack handshake. It is the receiving end of the countdown timer: it sits on the timer's `busy` output, so a timer loaded with N produces a reported count of N. The block is used for loopback checking and for timing external strobes in the same clock domain.

---
 rtl/pulse_meter.sv | 117 +++++++++++
 tb/tb_pulse_meter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Measures the length of each high pulse on `pulse` in clock cycles and hands the count to a
// consumer over a valid/ack handshake. The count saturates at 2^WIDTH-1 and the result is flagged.
module pulse_meter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse,
  input  logic             ack,
  output logic [WIDTH-1:0] cycles,
  output logic             valid,
  output logic             overflow,
  output logic             measuring,
  output logic             missed
);

  typedef enum logic [1:0] {StIdle, StMeasure, StHold} state_e;

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  state_e           state_q, state_d;
  logic             pulse_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] cycles_q, cycles_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             measuring_q, measuring_d;
  logic             missed_q, missed_d;
  logic             start;

  assign start = pulse & ~pulse_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sat_d       = sat_q;
    cycles_d    = cycles_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q;
    measuring_d = measuring_q;
    missed_d    = missed_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d     = CountOne;
          sat_d       = 1'b0;
          measuring_d = 1'b1;
          state_d     = StMeasure;
        end
      end
      StMeasure: begin
        if (pulse) begin
          if (count_q == CountMax) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + CountOne;
          end
        end else begin
          cycles_d    = count_q;
          overflow_d  = sat_q;
          valid_d     = 1'b1;
          sat_d       = 1'b0;
          measuring_d = 1'b0;
          state_d     = StHold;
        end
      end
      StHold: begin
        // A rise during HOLD is lost even if ack arrives on the same edge.
        if (start) begin
          missed_d = 1'b1;
        end
        if (ack) begin
          valid_d    = 1'b0;
          overflow_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // pulse_q resets high so a pulse already asserted at reset release is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pulse_q     <= 1'b1;
      count_q     <= '0;
      sat_q       <= 1'b0;
      cycles_q    <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      measuring_q <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse;
      count_q     <= count_d;
      sat_q       <= sat_d;
      cycles_q    <= cycles_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      measuring_q <= measuring_d;
      missed_q    <= missed_d;
    end
  end

  assign cycles    = cycles_q;
  assign valid     = valid_q;
  assign overflow  = overflow_q;
  assign measuring = measuring_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: a 16-bit instance fed by a small countdown timer or direct drive,
// and a 4-bit instance for saturation. Expected results queue up and are popped on each new valid.
module tb_pulse_meter;

  typedef struct {
    int unsigned cyc;
    bit          ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pulse_drv, ack;
  logic        pulse4, ack4;
  logic        pulse_in;
  logic [15:0] cycles;
  logic        valid, overflow, measuring, missed;
  logic [3:0]  cycles4;
  logic        valid4, overflow4, measuring4, missed4;

  logic        use_tmr = 1'b0;
  logic        tmr_load = 1'b0;
  int unsigned tmr_n = 0;
  int unsigned tmr_cnt = 0;
  logic        tmr_busy;

  int   total = 0;
  int   bad = 0;
  exp_t q16[$];
  exp_t q4[$];
  logic seen16 = 1'b0;
  logic seen4 = 1'b0;

  always #5 clk = ~clk;

  // Countdown timer: busy stays high for exactly tmr_n cycles after a load.
  always @(posedge clk) begin
    if (tmr_load) tmr_cnt <= tmr_n;
    else if (tmr_cnt != 0) tmr_cnt <= tmr_cnt - 1;
  end
  assign tmr_busy = (tmr_cnt != 0);
  assign pulse_in = use_tmr ? tmr_busy : pulse_drv;

  pulse_meter #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pulse     (pulse_in),
    .ack       (ack),
    .cycles    (cycles),
    .valid     (valid),
    .overflow  (overflow),
    .measuring (measuring),
    .missed    (missed)
  );

  pulse_meter #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .pulse     (pulse4),
    .ack       (ack4),
    .cycles    (cycles4),
    .valid     (valid4),
    .overflow  (overflow4),
    .measuring (measuring4),
    .missed    (missed4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push16(input int unsigned c, input bit o);
    exp_t e;
    e.cyc = c;
    e.ovf = o;
    q16.push_back(e);
  endtask

  task automatic push4(input int unsigned c, input bit o);
    exp_t e;
    e.cyc = c;
    e.ovf = o;
    q4.push_back(e);
  endtask

  task automatic drive_pulse(input int n);
    pulse_drv = 1'b1;
    repeat (n) tick();
    pulse_drv = 1'b0;
  endtask

  task automatic drive_pulse4(input int n);
    pulse4 = 1'b1;
    repeat (n) tick();
    pulse4 = 1'b0;
  endtask

  // Scoreboard: compare each freshly raised valid against the oldest expectation.
  always @(negedge clk) begin
    if (valid && !seen16) begin
      if (q16.size() == 0) begin
        check("unexpected_result16", 32'(cycles), 32'hffff_ffff);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("cycles16", 32'(cycles), e.cyc);
        check("overflow16", 32'(overflow), 32'(e.ovf));
      end
    end
    if (valid4 && !seen4) begin
      if (q4.size() == 0) begin
        check("unexpected_result4", 32'(cycles4), 32'hffff_ffff);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("cycles4", 32'(cycles4), e.cyc);
        check("overflow4", 32'(overflow4), 32'(e.ovf));
      end
    end
    seen16 <= valid;
    seen4  <= valid4;
  end

  initial begin
    int vlen;
    reset_n   = 1'b0;
    pulse_drv = 1'b1;
    ack       = 1'b1;
    pulse4    = 1'b0;
    ack4      = 1'b1;
    repeat (2) tick();
    check("rst_cycles", 32'(cycles), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_measuring", 32'(measuring), 0);
    check("rst_missed", 32'(missed), 0);

    // Pulse already high at reset release must be ignored until it falls and rises again.
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hi_at_release_measuring", 32'(measuring), 0);
      check("hi_at_release_valid", 32'(valid), 0);
    end
    pulse_drv = 1'b0;
    tick();
    push16(2, 1'b0);
    drive_pulse(2);
    repeat (3) tick();

    // Timer loopback with ack tied high.
    use_tmr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tmr_n    = (k == 0) ? 5 : 1;
      push16(tmr_n, 1'b0);
      tmr_load = 1'b1;
      tick();
      tmr_load = 1'b0;
      vlen = 0;
      repeat (12) begin
        tick();
        if (valid) vlen++;
      end
      check("loop_valid_len", 32'(vlen), 1);
    end
    use_tmr = 1'b0;

    // Handshake hold: ack low for 10 cycles, then high for one.
    ack = 1'b0;
    push16(3, 1'b0);
    drive_pulse(3);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(valid), 1);
      check("hold_cycles", 32'(cycles), 3);
      tick();
    end
    ack = 1'b1;
    check("hold_valid_at_ack", 32'(valid), 1);
    check("hold_cycles_at_ack", 32'(cycles), 3);
    tick();
    check("valid_after_ack", 32'(valid), 0);
    check("cycles_kept_after_ack", 32'(cycles), 3);

    // Missed pulse while a result is pending.
    ack = 1'b0;
    push16(4, 1'b0);
    drive_pulse(4);
    repeat (2) tick();
    drive_pulse(2);
    repeat (2) tick();
    check("missed_set", 32'(missed), 1);
    check("missed_cycles_kept", 32'(cycles), 4);
    check("missed_valid_kept", 32'(valid), 1);
    ack = 1'b1;
    tick();
    push16(6, 1'b0);
    drive_pulse(6);
    repeat (3) tick();
    check("missed_sticky", 32'(missed), 1);

    // Saturation on the 4-bit instance.
    push4(15, 1'b1);
    drive_pulse4(20);
    repeat (3) tick();
    push4(2, 1'b0);
    drive_pulse4(2);
    repeat (3) tick();
    check("sat_missed4", 32'(missed4), 0);

    // Reset in the middle of a measurement discards it.
    pulse_drv = 1'b1;
    repeat (2) tick();
    check("mid_measuring", 32'(measuring), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_measuring", 32'(measuring), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_cycles", 32'(cycles), 0);
    check("mid_rst_missed", 32'(missed), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    pulse_drv = 1'b0;
    tick();
    reset_n = 1'b1;
    vlen = 0;
    repeat (5) begin
      tick();
      if (valid) vlen++;
    end
    check("mid_rst_no_result", 32'(vlen), 0);

    // Rise sampled on the same edge as ack in HOLD: missed, never reported.
    ack = 1'b0;
    push16(3, 1'b0);
    drive_pulse(3);
    repeat (2) tick();
    ack = 1'b1;
    pulse_drv = 1'b1;
    repeat (3) tick();
    pulse_drv = 1'b0;
    repeat (2) tick();
    check("ack_rise_missed", 32'(missed), 1);
    check("ack_rise_valid", 32'(valid), 0);
    check("ack_rise_measuring", 32'(measuring), 0);
    push16(5, 1'b0);
    drive_pulse(5);
    repeat (4) tick();

    for (int i = 0; i < 20 && (q16.size() != 0 || q4.size() != 0); i++) tick();
    check("drain16", 32'(q16.size()), 0);
    check("drain4", 32'(q4.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
